// File: rtl/kf8255_bus_master_pkg.sv
// kf8255_bus_master_pkg: shared types and constants
// for the KF8255 host-bus initiator.
package kf8255_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  localparam logic [1:0] ADDR_PORT_A  = 2'd0;
  localparam logic [1:0] ADDR_PORT_B  = 2'd1;
  localparam logic [1:0] ADDR_PORT_C  = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  localparam logic [7:0] CTRL_RESET_WORD = 8'h9B;

  // Timer counts down to zero, so a phase of n cycles loads n-1.
  function automatic logic [7:0] phase_load(input int unsigned n);
    return (n == 0) ? 8'h00 : 8'(n - 1);
  endfunction

endpackage

// File: rtl/kf8255_bus_master_if.sv
// kf8255_bus_master_if: request/response handshake
// between a host and the KF8255 bus initiator.
interface kf8255_bus_master_if;
  logic       request_valid;
  logic       request_ready;
  logic       request_write;
  logic [1:0] request_address;
  logic [7:0] request_data;
  logic       response_valid;
  logic [7:0] response_data;

  modport master (
    output request_valid,
    output request_write,
    output request_address,
    output request_data,
    input  request_ready,
    input  response_valid,
    input  response_data
  );

  modport slave (
    input  request_valid,
    input  request_write,
    input  request_address,
    input  request_data,
    output request_ready,
    output response_valid,
    output response_data
  );
endinterface

// File: rtl/kf8255_bus_phase_timer.sv
// kf8255_bus_phase_timer: loadable 8-bit down-counter
// with terminal-count flag, times each bus phase.
module kf8255_bus_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       tc
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_value;
    else if (count_q != 8'd0)
      count_d = count_q - 8'd1;
  end

  assign tc = (count_q == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 8'd0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/kf8255_bus_master.sv
// kf8255_bus_master: timed 8255 bus-cycle initiator.
// Optional KF8255_BUS_MASTER_SHADOW_EN adds a control-word shadow.
module kf8255_bus_master
  import kf8255_bus_master_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES    = 1,
  parameter int unsigned STROBE_CYCLES   = 2,
  parameter int unsigned HOLD_CYCLES     = 1,
  parameter int unsigned RECOVERY_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  kf8255_bus_master_if.slave req,
  output logic       chip_select_n,
  output logic       read_enable_n,
  output logic       write_enable_n,
  output logic [1:0] address,
  output logic [7:0] data_bus_out,
  output logic       data_bus_out_enable,
  input  logic [7:0] data_bus_in
`ifdef KF8255_BUS_MASTER_SHADOW_EN
  ,
  output logic [7:0] control_shadow
`endif
);

  localparam logic [7:0] S_LD = phase_load(SETUP_CYCLES);
  localparam logic [7:0] T_LD = phase_load(STROBE_CYCLES);
  localparam logic [7:0] H_LD = phase_load(HOLD_CYCLES);
  localparam logic [7:0] R_LD = phase_load(RECOVERY_CYCLES);

  state_e     state_q, state_d;
  logic       wr_q, wr_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       oe_q, oe_d;
  logic       rsp_v_q, rsp_v_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       load, tc, accept, skip, act;
  logic [7:0] load_val;

`ifdef KF8255_BUS_MASTER_SHADOW_EN
  logic [7:0] shadow_q, shadow_d;
  logic       ctl_word;
`endif

  kf8255_bus_phase_timer u_timer (
    .clk        (clock),
    .rst_n      (reset_n),
    .load       (load),
    .load_value (load_val),
    .tc         (tc)
  );

  always_comb begin
    accept = req.request_valid && (state_q == ST_IDLE);
    skip   = 1'b0;
`ifdef KF8255_BUS_MASTER_SHADOW_EN
    // A repeated mode-set word needs no bus cycle.
    ctl_word = req.request_write
            && (req.request_address == ADDR_CONTROL)
            && req.request_data[7];
    skip     = ctl_word && (req.request_data == shadow_q);
    shadow_d = (accept && ctl_word) ? req.request_data : shadow_q;
`endif
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    load       = 1'b0;
    load_val   = 8'h00;
    rsp_v_d    = 1'b0;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && !skip) begin
          wr_d     = req.request_write;
          addr_d   = req.request_address;
          wdata_d  = req.request_data;
          state_d  = ST_SETUP;
          load     = 1'b1;
          load_val = S_LD;
        end
      end
      ST_SETUP: begin
        if (tc) begin
          state_d  = ST_STROBE;
          load     = 1'b1;
          load_val = T_LD;
        end
      end
      ST_STROBE: begin
        if (tc) begin
          state_d  = ST_HOLD;
          load     = 1'b1;
          load_val = H_LD;
          rsp_v_d  = !wr_q;
          if (!wr_q) rsp_data_d = data_bus_in;
        end
      end
      ST_HOLD: begin
        if (tc) begin
          if (RECOVERY_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_RECOVER;
            load     = 1'b1;
            load_val = R_LD;
          end
        end
      end
      ST_RECOVER: begin
        if (tc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus pins are decoded from the next state and registered.
    act    = (state_d == ST_SETUP) || (state_d == ST_STROBE)
          || (state_d == ST_HOLD);
    cs_n_d = !act;
    oe_d   = act && wr_d;
    rd_n_d = 1'b1;
    wr_n_d = 1'b1;
    if (state_d == ST_STROBE) begin
      unique case (1'b1)
        wr_d:  wr_n_d = 1'b0;
        !wr_d: rd_n_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      addr_q     <= 2'd0;
      wdata_q    <= 8'h00;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      rsp_v_q    <= 1'b0;
      rsp_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      oe_q       <= oe_d;
      rsp_v_q    <= rsp_v_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef KF8255_BUS_MASTER_SHADOW_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) shadow_q <= CTRL_RESET_WORD;
    else          shadow_q <= shadow_d;
  end

  assign control_shadow = shadow_q;
`endif

  assign req.request_ready    = (state_q == ST_IDLE);
  assign req.response_valid   = rsp_v_q;
  assign req.response_data    = rsp_data_q;
  assign chip_select_n        = cs_n_q;
  assign read_enable_n        = rd_n_q;
  assign write_enable_n       = wr_n_q;
  assign address              = addr_q;
  assign data_bus_out         = wdata_q;
  assign data_bus_out_enable  = oe_q;

endmodule
